// File: rtl/vlsu_sequencer.sv
// Vector load/store sequencer: splits one vector memory instruction into 4-lane beats.
// Build option: VLSU_MASK_AGNOSTIC_EN fills masked-off/tail load elements with all-ones.

module vlsu_lane #(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int LANE = 0
) (
  input  logic            issue_i,
  input  logic [1:0]      beat_i,
  input  logic [4:0]      vl_i,
  input  logic [1:0]      sew_i,
  input  logic            store_i,
  input  logic            vm_i,
  input  logic [15:0]     mask_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] stride_i,
  input  logic [VLEN-1:0] vs3_i,
  output logic            act_o,
  output logic [3:0]      elem_o,
  output logic [XLEN-1:0] addr_o,
  output logic [2:0]      we_o,
  output logic [2:0]      re_o,
  output logic [31:0]     wdata_o
);
  localparam logic [1:0]      LID  = 2'(LANE);
  localparam logic [XLEN-1:0] LOFF = XLEN'(LANE);

  logic [2:0]  size;
  logic [31:0] elt;

  assign elem_o = {beat_i, LID};
  assign act_o  = issue_i && ({1'b0, elem_o} < vl_i) && (vm_i || mask_i[elem_o]);

  always_comb begin
    size = 3'b100;
    elt  = vs3_i[elem_o[1:0]*32 +: 32];
    case (sew_i)
      2'b00: begin size = 3'b001; elt = {24'b0, vs3_i[elem_o*8 +: 8]}; end
      2'b01: begin size = 3'b010; elt = {16'b0, vs3_i[elem_o[2:0]*16 +: 16]}; end
      default: ;
    endcase
  end

  assign addr_o  = act_o ? base_i + LOFF * stride_i : '0;
  assign we_o    = (act_o && store_i)  ? size : 3'b000;
  assign re_o    = (act_o && !store_i) ? size : 3'b000;
  assign wdata_o = (act_o && store_i)  ? elt  : 32'b0;
endmodule

module vlsu_sequencer #(
  parameter int VLEN  = 128,
  parameter int XLEN  = 32,
  parameter int LANES = 4,
  parameter int MAXEL = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_stride,
  input  logic [4:0]      req_vl,
  input  logic [1:0]      req_sew,
  input  logic            req_vm,
  input  logic [15:0]     req_mask,
  input  logic [VLEN-1:0] req_vd_old,
  input  logic [VLEN-1:0] req_vs3,
  output logic [XLEN-1:0] lane_addr0,
  output logic [XLEN-1:0] lane_addr1,
  output logic [XLEN-1:0] lane_addr2,
  output logic [XLEN-1:0] lane_addr3,
  output logic [2:0]      lane_we0,
  output logic [2:0]      lane_we1,
  output logic [2:0]      lane_we2,
  output logic [2:0]      lane_we3,
  output logic [2:0]      lane_re0,
  output logic [2:0]      lane_re1,
  output logic [2:0]      lane_re2,
  output logic [2:0]      lane_re3,
  output logic            lane_vm0,
  output logic            lane_vm1,
  output logic            lane_vm2,
  output logic            lane_vm3,
  output logic [VLEN-1:0] lane_wdata,
  input  logic [VLEN-1:0] lane_rdata,
  output logic            stall,
  output logic            done_valid,
  output logic [VLEN-1:0] done_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e          state_q;
  logic [1:0]      beat_q;
  logic [2:0]      beats_q;
  logic [4:0]      vl_q;
  logic [1:0]      sew_q;
  logic            store_q, vm_q;
  logic [15:0]     mask_q;
  logic [XLEN-1:0] base_q, stride_q;
  logic [VLEN-1:0] vs3_q, res_q, res_d;

  logic [1:0]      sew_n;
  logic [4:0]      maxvl_n, vl_n;
  logic [2:0]      beats_n;
  logic [VLEN-1:0] res_init;
  logic            issue;

  logic [LANES-1:0]           act;
  logic [LANES-1:0][3:0]      elem;
  logic [LANES-1:0][XLEN-1:0] addr;
  logic [LANES-1:0][2:0]      we, re;
  logic [LANES-1:0][31:0]     wd;

  // Accept-time decode: SEW 11 aliases to 32b, vl clamps to VLEN/SEW.
  assign sew_n   = (req_sew == 2'b11) ? 2'b10 : req_sew;
  assign maxvl_n = 5'(MAXEL) >> sew_n;
  assign vl_n    = (req_vl > maxvl_n) ? maxvl_n : req_vl;
  assign beats_n = 3'((vl_n + 5'd3) >> 2);

`ifdef VLSU_MASK_AGNOSTIC_EN
  // Active elements get overwritten, so preloading ones leaves only masked/tail as ones.
  assign res_init = (!req_store && vl_n != 5'd0) ? '1 : req_vd_old;
`else
  assign res_init = req_vd_old;
`endif

  assign issue = (state_q == ISSUE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vlsu_lane #(.XLEN(XLEN), .VLEN(VLEN), .LANE(l)) u_lane (
      .issue_i (issue),
      .beat_i  (beat_q),
      .vl_i    (vl_q),
      .sew_i   (sew_q),
      .store_i (store_q),
      .vm_i    (vm_q),
      .mask_i  (mask_q),
      .base_i  (base_q),
      .stride_i(stride_q),
      .vs3_i   (vs3_q),
      .act_o   (act[l]),
      .elem_o  (elem[l]),
      .addr_o  (addr[l]),
      .we_o    (we[l]),
      .re_o    (re[l]),
      .wdata_o (wd[l])
    );
  end

  always_comb begin
    res_d = res_q;
    if (issue && !store_q) begin
      for (int l = 0; l < LANES; l++) begin
        if (act[l]) begin
          case (sew_q)
            2'b00:   res_d[elem[l]*8 +: 8]        = lane_rdata[32*l +: 8];
            2'b01:   res_d[elem[l][2:0]*16 +: 16] = lane_rdata[32*l +: 16];
            default: res_d[elem[l][1:0]*32 +: 32] = lane_rdata[32*l +: 32];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      beats_q  <= '0;
      vl_q     <= '0;
      sew_q    <= '0;
      store_q  <= 1'b0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      vs3_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          beat_q   <= '0;
          beats_q  <= beats_n;
          vl_q     <= vl_n;
          sew_q    <= sew_n;
          store_q  <= req_store;
          vm_q     <= req_vm;
          mask_q   <= req_mask;
          base_q   <= req_base;
          stride_q <= req_stride;
          vs3_q    <= req_vs3;
          res_q    <= res_init;
          state_q  <= (vl_n == 5'd0) ? DONE : ISSUE;
        end
        ISSUE: begin
          res_q  <= res_d;
          base_q <= base_q + (stride_q << 2);
          beat_q <= beat_q + 2'd1;
          if ({1'b0, beat_q} == beats_q - 3'd1) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q == IDLE) ? req_valid : issue;
  assign done_valid = (state_q == DONE);
  assign done_data  = done_valid ? res_q : '0;

  assign lane_addr0 = addr[0];
  assign lane_addr1 = addr[1];
  assign lane_addr2 = addr[2];
  assign lane_addr3 = addr[3];
  assign lane_we0   = we[0];
  assign lane_we1   = we[1];
  assign lane_we2   = we[2];
  assign lane_we3   = we[3];
  assign lane_re0   = re[0];
  assign lane_re1   = re[1];
  assign lane_re2   = re[2];
  assign lane_re3   = re[3];
  assign lane_vm0   = act[0];
  assign lane_vm1   = act[1];
  assign lane_vm2   = act[2];
  assign lane_vm3   = act[3];
  assign lane_wdata = wd;
endmodule

// File: tb/tb_vlsu_sequencer.sv
// Directed bench for vlsu_sequencer: hand-computed beats, addresses and results.

module tb_vlsu_sequencer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_store, req_vm;
  logic [31:0]  req_base, req_stride;
  logic [4:0]   req_vl;
  logic [1:0]   req_sew;
  logic [15:0]  req_mask;
  logic [127:0] req_vd_old, req_vs3;
  logic [31:0]  lane_addr0, lane_addr1, lane_addr2, lane_addr3;
  logic [2:0]   lane_we0, lane_we1, lane_we2, lane_we3;
  logic [2:0]   lane_re0, lane_re1, lane_re2, lane_re3;
  logic         lane_vm0, lane_vm1, lane_vm2, lane_vm3;
  logic [127:0] lane_wdata, lane_rdata, done_data;
  logic         stall, done_valid;

  int n_chk = 0;
  int n_err = 0;

  vlsu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl),
    .req_sew(req_sew), .req_vm(req_vm), .req_mask(req_mask),
    .req_vd_old(req_vd_old), .req_vs3(req_vs3),
    .lane_addr0(lane_addr0), .lane_addr1(lane_addr1),
    .lane_addr2(lane_addr2), .lane_addr3(lane_addr3),
    .lane_we0(lane_we0), .lane_we1(lane_we1), .lane_we2(lane_we2), .lane_we3(lane_we3),
    .lane_re0(lane_re0), .lane_re1(lane_re1), .lane_re2(lane_re2), .lane_re3(lane_re3),
    .lane_vm0(lane_vm0), .lane_vm1(lane_vm1), .lane_vm2(lane_vm2), .lane_vm3(lane_vm3),
    .lane_wdata(lane_wdata), .lane_rdata(lane_rdata),
    .stall(stall), .done_valid(done_valid), .done_data(done_data)
  );

  always #5 clk = ~clk;

  wire [11:0] we_cat = {lane_we3, lane_we2, lane_we1, lane_we0};
  wire [11:0] re_cat = {lane_re3, lane_re2, lane_re1, lane_re0};
  wire [3:0]  vm_cat = {lane_vm3, lane_vm2, lane_vm1, lane_vm0};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one request at the negedge, check accept-cycle outputs, then
  // scramble the request fields so that only latched values can matter.
  task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] stride,
                       input logic [4:0] vl, input logic [1:0] sew, input logic vm,
                       input logic [15:0] mask, input logic [127:0] vdold, input logic [127:0] vs3);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_base = base; req_stride = stride;
    req_vl = vl; req_sew = sew; req_vm = vm; req_mask = mask;
    req_vd_old = vdold; req_vs3 = vs3;
    #1;
    chk("acc_ready", 128'(req_ready), 128'd1);
    chk("acc_stall", 128'(stall), 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = ~st; req_base = 32'hDEAD_0000; req_stride = 32'h77;
    req_vl = 5'd16; req_sew = 2'b00; req_vm = 1'b1; req_mask = 16'h0;
    req_vd_old = '1; req_vs3 = '1;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0;
    req_vl = '0; req_sew = '0; req_vm = 1'b0; req_mask = '0; req_vd_old = '0;
    req_vs3 = '0; lane_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_stall", 128'(stall), 128'd0);
    chk("rst_done", 128'(done_valid), 128'd0);
    chk("rst_data", done_data, 128'd0);
    chk("rst_we", 128'(we_cat), 128'd0);
    chk("rst_addr0", 128'(lane_addr0), 128'd0);
    chk("rst_wdata", lane_wdata, 128'd0);
    rst_n = 1'b1;

    // 1: unit-stride word load, one beat
    issue(1'b0, 32'h100, 32'd4, 5'd4, 2'b10, 1'b1, 16'h0, {4{32'hCAFE_F00D}}, '0);
    lane_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
    #1;
    chk("t1_addr0", 128'(lane_addr0), 128'h100);
    chk("t1_addr1", 128'(lane_addr1), 128'h104);
    chk("t1_addr2", 128'(lane_addr2), 128'h108);
    chk("t1_addr3", 128'(lane_addr3), 128'h10C);
    chk("t1_re", 128'(re_cat), 128'(12'b100_100_100_100));
    chk("t1_we", 128'(we_cat), 128'd0);
    chk("t1_vm", 128'(vm_cat), 128'hF);
    chk("t1_stall", 128'(stall), 128'd1);
    step();
    chk("t1_done", 128'(done_valid), 128'd1);
    chk("t1_data", done_data, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("t1_dstall", 128'(stall), 128'd0);
    chk("t1_dready", 128'(req_ready), 128'd0);
    chk("t1_dre", 128'(re_cat), 128'd0);
    step();
    chk("t1_idle_done", 128'(done_valid), 128'd0);
    chk("t1_idle_ready", 128'(req_ready), 128'd1);

    // 2: byte store, vl=10 -> 3 beats, partial last beat
    issue(1'b1, 32'h20, 32'd1, 5'd10, 2'b00, 1'b1, 16'h0,
          {4{32'h5A5A_A5A5}}, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("t2b0_we", 128'(we_cat), 128'(12'b001_001_001_001));
    chk("t2b0_addr0", 128'(lane_addr0), 128'h20);
    chk("t2b0_addr3", 128'(lane_addr3), 128'h23);
    chk("t2b0_wd", lane_wdata, {32'h3, 32'h2, 32'h1, 32'h0});
    step();
    chk("t2b1_addr0", 128'(lane_addr0), 128'h24);
    chk("t2b1_wd", lane_wdata, {32'h7, 32'h6, 32'h5, 32'h4});
    step();
    chk("t2b2_we", 128'(we_cat), 128'(12'b000_000_001_001));
    chk("t2b2_addr0", 128'(lane_addr0), 128'h28);
    chk("t2b2_addr1", 128'(lane_addr1), 128'h29);
    chk("t2b2_addr2", 128'(lane_addr2), 128'h0);
    chk("t2b2_wd", lane_wdata, {32'h0, 32'h0, 32'h9, 32'h8});
    chk("t2b2_done", 128'(done_valid), 128'd0);
    step();
    chk("t2_done", 128'(done_valid), 128'd1);
    chk("t2_data", done_data, {4{32'h5A5A_A5A5}});
    chk("t2_dwe", 128'(we_cat), 128'd0);
    step();

    // 3: masked halfword load, elements 0,2,5,7 active
    issue(1'b0, 32'h200, 32'd2, 5'd8, 2'b01, 1'b0, 16'h00A5, {8{16'hBEEF}}, '0);
    lane_rdata = {32'hDEAD0103, 32'hDEAD0102, 32'hDEAD0101, 32'hDEAD0100};
    #1;
    chk("t3b0_vm", 128'(vm_cat), 128'b0101);
    chk("t3b0_re", 128'(re_cat), 128'(12'b000_010_000_010));
    chk("t3b0_addr2", 128'(lane_addr2), 128'h204);
    chk("t3b0_addr1", 128'(lane_addr1), 128'h0);
    step();
    lane_rdata = {32'hDEAD0107, 32'hDEAD0106, 32'hDEAD0105, 32'hDEAD0104};
    #1;
    chk("t3b1_vm", 128'(vm_cat), 128'b1010);
    chk("t3b1_addr3", 128'(lane_addr3), 128'h20E);
    step();
    chk("t3_done", 128'(done_valid), 128'd1);
`ifdef VLSU_MASK_AGNOSTIC_EN
    chk("t3_data", done_data, {{4{16'hFFFF}}, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                               16'h0107, 16'hFFFF, 16'h0105, 16'hFFFF,
                               16'hFFFF, 16'h0102, 16'hFFFF, 16'h0100});
`else
    chk("t3_data", done_data, {{4{16'hBEEF}}, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF,
                               16'h0107, 16'hBEEF, 16'h0105, 16'hBEEF,
                               16'hBEEF, 16'h0102, 16'hBEEF, 16'h0100});
`endif
    step();
    lane_rdata = '0;

    // 4: strided word load wrapping through 2^32
    issue(1'b0, 32'hFFFF_FFF8, 32'd8, 5'd4, 2'b10, 1'b1, 16'h0, '0, '0);
    chk("t4_addr0", 128'(lane_addr0), 128'hFFFF_FFF8);
    chk("t4_addr1", 128'(lane_addr1), 128'h0);
    chk("t4_addr2", 128'(lane_addr2), 128'h8);
    chk("t4_addr3", 128'(lane_addr3), 128'h10);
    step();
    chk("t4_done", 128'(done_valid), 128'd1);
    step();

    // 5: vl=0 load goes straight to DONE with vd_old
    issue(1'b0, 32'h300, 32'd4, 5'd0, 2'b10, 1'b1, 16'h0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0);
    chk("t5_done", 128'(done_valid), 128'd1);
    chk("t5_data", done_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t5_en", 128'({re_cat, we_cat, vm_cat}), 128'd0);
    step();
    chk("t5_ready", 128'(req_ready), 128'd1);

    // 6: sew=11 acts as 32b, vl=9 clamps to 4 -> single beat
    issue(1'b0, 32'h400, 32'd4, 5'd9, 2'b11, 1'b1, 16'h0, '0, '0);
    chk("t6_vm", 128'(vm_cat), 128'hF);
    chk("t6_re", 128'(re_cat), 128'(12'b100_100_100_100));
    step();
    chk("t6_done", 128'(done_valid), 128'd1);
    step();

    // 7: reset during beat 1 of a 3-beat store
    issue(1'b1, 32'h20, 32'd1, 5'd10, 2'b00, 1'b1, 16'h0, '0, '0);
    step();
    chk("t7_b1_addr0", 128'(lane_addr0), 128'h24);
    rst_n = 1'b0;
    step();
    chk("t7_we", 128'(we_cat), 128'd0);
    chk("t7_ready", 128'(req_ready), 128'd1);
    chk("t7_done", 128'(done_valid), 128'd0);
    chk("t7_stall", 128'(stall), 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t7_quiet", 128'({done_valid, we_cat}), 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vlsu_sequencer.md
Name: vlsu_sequencer

Overview:
- Vector load/store sequencer that sits directly upstream of the scalar/vector datapath's 4-port data memory.
- Accepts one vector memory instruction (unit-stride or strided, SEW 8/16/32) and splits it into 4-lane beats.
- Drives per-lane addresses, write/read enables, masks and store data into the datapath.
- Gathers per-lane load data into a VLEN-wide result and stalls the PC until the instruction completes.

Parameters:
- VLEN, 128, vector register width in bits.
- XLEN, 32, scalar/address width.
- LANES, 4, memory ports per beat; fixed at 4.
- MAXEL, 16, maximum element count (VLEN/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  vector memory instruction present
- req_ready  out  1  sequencer can accept
- req_store  in  1  1=store, 0=load
- req_base  in  XLEN  base byte address (rs1)
- req_stride  in  XLEN  byte stride; unit-stride passes SEW/8
- req_vl  in  5  element count, 0..16
- req_sew  in  2  00=8b, 01=16b, 10=32b; 11 treated as 10
- req_vm  in  1  1=unmasked
- req_mask  in  16  v0 mask bits, bit e gates element e
- req_vd_old  in  VLEN  old destination contents
- req_vs3  in  VLEN  store source vector
- lane_addr0..lane_addr3  out  XLEN  per-lane byte address
- lane_we0..lane_we3  out  3  store size: 001 byte, 010 half, 100 word, 000 none
- lane_re0..lane_re3  out  3  load size, same encoding
- lane_vm0..lane_vm3  out  1  lane active
- lane_wdata  out  VLEN  lane l store data in bits [32l+31:32l]
- lane_rdata  in  VLEN  lane l load data in bits [32l+31:32l], same-cycle combinational from memory
- stall  out  1  hold PC
- done_valid  out  1  one-cycle completion pulse
- done_data  out  VLEN  load result (valid with done_valid)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; req_ready=1; stall=0; done_valid=0; done_data=0; all lane_we/re/vm=0; lane_addr=0; lane_wdata=0; result buffer=0.
- FSM: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready=1; stall=req_valid.
  - On req_valid, latch all req_* fields.
  - Go to ISSUE, or to DONE if vl=0.
- vl clamp: vl is clamped to VLEN/SEW (16/8/4).
- Beats: beats B=ceil(vl/4). A beat counter runs 0..B-1, one beat per cycle, no wait states.
- ISSUE, beat b, lane l:
  - Element e=4b+l.
  - Lane active iff e<vl and (vm or mask[e]).
  - lane_addr_l = beat_base + l*stride, modulo 2^XLEN.
  - beat_base starts at base and advances by 4*stride each beat, wrapping.
  - Inactive lanes: we=re=vm=0; addr is don't-care but must be driven to 0.
- Store: lane_we_l = size code for SEW; lane_wdata lane l = element e of vs3 (bits [e*SEW +: SEW]), zero-extended to 32 bits.
- Load: lane_re_l = size code. At the end of the cycle, the low SEW bits of lane_rdata lane l are written into result element e for active lanes.
- Result buffer: loaded with vd_old at accept. Inactive and tail elements keep vd_old (mask/tail undisturbed).
- ISSUE stall: stall=1 throughout ISSUE. After beat B-1, go to DONE.
- DONE (exactly 1 cycle):
  - done_valid=1; done_data=result (for stores, result=vd_old).
  - stall=0, so the PC advances at this edge. req_ready=0 and req_valid is ignored.
  - Next state is IDLE.
- Latency: accept at cycle T; ISSUE T+1..T+B; DONE at T+B+1. The vl=0 case gives DONE at T+1.
- Enables: all lane enables are 0 outside ISSUE.
- Reset mid-operation: returns to IDLE immediately at the edge. No further enables are driven and no done_valid pulse is produced.
- Latched fields: changes to req_* during ISSUE/DONE have no effect.

Optional Feature:
- Macro: VLSU_MASK_AGNOSTIC_EN.
- Defined: masked-off and tail elements of a load result are written all-ones (mask/tail agnostic) instead of vd_old. Stores are unaffected.
- Undefined: undisturbed behaviour as above.

Test Plan:
- Unit-stride word load, base=0x100, stride=4, sew=10, vl=4, vm=1, rdata lanes=0x11,0x22,0x33,0x44 → one ISSUE beat with addr 0x100/104/108/10C and re=100 on all lanes; done_data={0x44,0x33,0x22,0x11} at T+2; stall high for T and T+1.
- Byte store, sew=00, vl=10, stride=1, base=0x20 → 3 beats.
  - Beat 2 has lanes 0-1 active at 0x28/0x29 with we=001 and lanes 2-3 we=000.
  - done_valid at T+4.
- Masked halfword load, vl=8, vm=0, mask=0x00A5, vd_old=all 0xBEEF → only elements 0,2,5,7 take rdata; others remain 0xBEEF. With VLSU_MASK_AGNOSTIC_EN defined, the others are 0xFFFF.
- Strided with wrap, base=0xFFFFFFF8, stride=8, sew=10, vl=4 → addresses 0xFFFFFFF8, 0x0, 0x8, 0x10.
- vl=0 load → no enables ever asserted; done_valid at T+1 with done_data=vd_old.
- Reset during beat 1 of a 3-beat store → next cycle all we=0, state IDLE, req_ready=1, no done_valid.
